// File: rtl/multiplicador_secuencial_if.sv
// Operand/result bus between the register bank and the sequential multiplier.
// The master drives the request and operands; the slave returns the result, the bank write and the flags.
interface multiplicador_secuencial_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic             flush;
    logic             acc_en;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] op_c;
    logic [3:0]       rd_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [3:0]       wa3;
    logic             we3;
    logic             flag_n;
    logic             flag_z;

    modport master (
        output start, flush, acc_en, op_a, op_b, op_c, rd_in,
        input  busy, done, result, wa3, we3, flag_n, flag_z
    );

    modport slave (
        input  start, flush, acc_en, op_a, op_b, op_c, rd_in,
        output busy, done, result, wa3, we3, flag_n, flag_z
    );
endinterface

// File: rtl/multiplicador_secuencial.sv
// Iterative shift-add multiplier for MUL/MLA: low WIDTH bits of op_a*op_b (+ op_c),
// one multiplier bit per cycle, with optional early exit once the remaining multiplier bits are zero.
module multiplicador_secuencial #(
    parameter int unsigned WIDTH      = 32,
    parameter bit          EARLY_TERM = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    multiplicador_secuencial_if.slave  bus
);
    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [3:0]       rd;
    logic [CW-1:0]    cnt;

    logic             busy_q;
    logic             done_q;
    logic             we3_q;
    logic [WIDTH-1:0] result_q;
    logic [3:0]       wa3_q;
    logic             flag_n_q;
    logic             flag_z_q;

    logic [WIDTH-1:0] acc_sum;
    logic [WIDTH-1:0] mplier_sh;
    logic             last_iter;

    // Datapath for one iteration; exit is judged on the already-shifted multiplier
    always_comb begin
        acc_sum   = mplier[0] ? acc + mcand : acc;
        mplier_sh = mplier >> 1;
        last_iter = (cnt == CW'(WIDTH - 1)) || (EARLY_TERM && (mplier_sh == '0));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            mcand    <= '0;
            mplier   <= '0;
            acc      <= '0;
            rd       <= '0;
            cnt      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            we3_q    <= 1'b0;
            result_q <= '0;
            wa3_q    <= '0;
            flag_n_q <= 1'b0;
            flag_z_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            we3_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start && !bus.flush) begin
                        state  <= RUN;
                        busy_q <= 1'b1;
                        mcand  <= bus.op_a;
                        mplier <= bus.op_b;
                        acc    <= bus.acc_en ? bus.op_c : '0;
                        rd     <= bus.rd_in;
                        cnt    <= '0;
                    end
                end
                RUN: begin
                    if (bus.flush) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else begin
                        acc    <= acc_sum;
                        mcand  <= mcand << 1;
                        mplier <= mplier_sh;
                        cnt    <= cnt + 1'b1;
                        if (last_iter) begin
                            // R15 is not writable from here: report completion without a bank write
                            state    <= DONE;
                            done_q   <= 1'b1;
                            we3_q    <= (rd != 4'd15);
                            wa3_q    <= rd;
                            result_q <= acc_sum;
                            flag_n_q <= acc_sum[WIDTH-1];
                            flag_z_q <= (acc_sum == '0);
                        end
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.we3    = we3_q;
    assign bus.result = result_q;
    assign bus.wa3    = wa3_q;
    assign bus.flag_n = flag_n_q;
    assign bus.flag_z = flag_z_q;
endmodule

// File: tb/tb_multiplicador_secuencial.sv
// Bench for multiplicador_secuencial: two instances (early exit on/off) driven by the same directed
// vectors, checked every cycle against a cycle-count model plus literal expectations per vector.
module tb_multiplicador_secuencial;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic        acc_en = 1'b0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic [31:0] op_c = '0;
    logic [3:0]  rd_in = '0;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    multiplicador_secuencial_if #(.WIDTH(32)) b1 ();
    multiplicador_secuencial_if #(.WIDTH(32)) b0 ();

    assign b1.start = start;  assign b0.start = start;
    assign b1.flush = flush;  assign b0.flush = flush;
    assign b1.acc_en = acc_en; assign b0.acc_en = acc_en;
    assign b1.op_a = op_a;    assign b0.op_a = op_a;
    assign b1.op_b = op_b;    assign b0.op_b = op_b;
    assign b1.op_c = op_c;    assign b0.op_c = op_c;
    assign b1.rd_in = rd_in;  assign b0.rd_in = rd_in;

    multiplicador_secuencial #(.WIDTH(32), .EARLY_TERM(1'b1)) dut_et1 (.clk(clk), .rst(rst), .bus(b1.slave));
    multiplicador_secuencial #(.WIDTH(32), .EARLY_TERM(1'b0)) dut_et0 (.clk(clk), .rst(rst), .bus(b0.slave));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: index 1 = early exit enabled, index 0 = always WIDTH iterations
    logic        m_busy [2] = '{1'b0, 1'b0};
    logic        m_done [2] = '{1'b0, 1'b0};
    logic        m_we3  [2] = '{1'b0, 1'b0};
    logic        m_n    [2] = '{1'b0, 1'b0};
    logic        m_z    [2] = '{1'b0, 1'b0};
    logic [31:0] m_res  [2] = '{32'd0, 32'd0};
    logic [3:0]  m_wa3  [2] = '{4'd0, 4'd0};
    logic [31:0] p_res  [2] = '{32'd0, 32'd0};
    logic [3:0]  p_rd   [2] = '{4'd0, 4'd0};
    int          left   [2] = '{0, 0};

    function automatic int iters(input logic [31:0] b, input bit et);
        if (!et) return 32;
        for (int j = 31; j >= 0; j--) if (b[j]) return j + 1;
        return 1;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                m_busy[i] = 0; m_done[i] = 0; m_we3[i] = 0; m_n[i] = 0; m_z[i] = 0;
                m_res[i] = '0; m_wa3[i] = '0; left[i] = 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                m_done[i] = 0;
                m_we3[i]  = 0;
                if (!m_busy[i]) begin
                    if (start && !flush) begin
                        m_busy[i] = 1;
                        left[i]   = iters(op_b, i == 1);
                        p_res[i]  = op_a * op_b + (acc_en ? op_c : 32'd0);
                        p_rd[i]   = rd_in;
                    end
                end else if (flush) begin
                    m_busy[i] = 0;
                    left[i]   = 0;
                end else if (left[i] > 0) begin
                    left[i]--;
                    if (left[i] == 0) begin
                        m_done[i] = 1;
                        m_we3[i]  = (p_rd[i] != 4'd15);
                        m_res[i]  = p_res[i];
                        m_wa3[i]  = p_rd[i];
                        m_n[i]    = p_res[i][31];
                        m_z[i]    = (p_res[i] == 32'd0);
                    end
                end else begin
                    m_busy[i] = 0;
                end
            end
        end
    end

    task automatic cmp(input int i, input logic bsy, input logic dn, input logic we,
                       input logic [31:0] res, input logic [3:0] wa, input logic n, input logic z);
        string p;
        p = (i == 1) ? "et1" : "et0";
        chk({p, ".busy"}, 32'(bsy), 32'(m_busy[i]));
        chk({p, ".done"}, 32'(dn), 32'(m_done[i]));
        chk({p, ".we3"}, 32'(we), 32'(m_we3[i]));
        chk({p, ".result"}, res, m_res[i]);
        chk({p, ".wa3"}, 32'(wa), 32'(m_wa3[i]));
        chk({p, ".flag_n"}, 32'(n), 32'(m_n[i]));
        chk({p, ".flag_z"}, 32'(z), 32'(m_z[i]));
    endtask

    always @(negedge clk) begin
        cmp(1, b1.busy, b1.done, b1.we3, b1.result, b1.wa3, b1.flag_n, b1.flag_z);
        cmp(0, b0.busy, b0.done, b0.we3, b0.result, b0.wa3, b0.flag_n, b0.flag_z);
    end

    // Issues one request in cycle 0 and watches `len` cycles; e1/e0 are the expected done cycles (0 = none)
    task automatic run(input string nm, input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                       input logic acc, input logic [3:0] rd, input int flush_cyc, input int alt_cyc,
                       input int len, input int e1, input int e0, input logic [31:0] er,
                       input logic ew, input logic en, input logic ez);
        int d1, d0, n1;
        logic [31:0] r1;
        logic w1, f_n, f_z;
        d1 = 0; d0 = 0; n1 = 0; r1 = '0; w1 = 0; f_n = 0; f_z = 0;
        op_a = a; op_b = b; op_c = c; acc_en = acc; rd_in = rd; flush = 0; start = 1;
        @(posedge clk); #1;
        start = 0;
        for (int cyc = 1; cyc < len; cyc++) begin
            flush = (cyc == flush_cyc);
            start = (cyc == alt_cyc);
            if (cyc == alt_cyc) begin op_a = 32'd99; op_b = 32'd1; end
            @(negedge clk);
            if (b1.done) begin
                n1++;
                if (d1 == 0) begin d1 = cyc; r1 = b1.result; w1 = b1.we3; f_n = b1.flag_n; f_z = b1.flag_z; end
            end
            if (b0.done && d0 == 0) d0 = cyc;
            @(posedge clk); #1;
        end
        flush = 0; start = 0;
        chk({nm, " et1 done cycle"}, 32'(d1), 32'(e1));
        chk({nm, " et0 done cycle"}, 32'(d0), 32'(e0));
        if (e1 != 0) begin
            chk({nm, " done count"}, 32'(n1), 32'd1);
            chk({nm, " result"}, r1, er);
            chk({nm, " we3"}, 32'(w1), 32'(ew));
            chk({nm, " flag_n"}, 32'(f_n), 32'(en));
            chk({nm, " flag_z"}, 32'(f_z), 32'(ez));
        end
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, " busy"}, 32'({b1.busy, b0.busy}), 32'd0);
        chk({nm, " done"}, 32'({b1.done, b0.done}), 32'd0);
        chk({nm, " we3"}, 32'({b1.we3, b0.we3}), 32'd0);
        chk({nm, " flags"}, 32'({b1.flag_n, b1.flag_z, b0.flag_n, b0.flag_z}), 32'd0);
        chk({nm, " et1 result"}, b1.result, 32'd0);
        chk({nm, " et0 result"}, b0.result, 32'd0);
        chk({nm, " wa3"}, 32'({b1.wa3, b0.wa3}), 32'd0);
    endtask

    initial begin
        #1 rst = 0;
        #11 chk_zero("reset");
        #1 rst = 1;
        @(posedge clk); #1;

        run("mul7x6",   32'd7,          32'd6,          32'd0, 1'b0, 4'd3,  0, 0, 36, 4,  33, 32'd42,         1'b1, 1'b0, 1'b0);
        run("mla_wrap", 32'hFFFF_FFFF,  32'd2,          32'd5, 1'b1, 4'd4,  0, 0, 36, 3,  33, 32'h0000_0003,  1'b1, 1'b0, 1'b0);
        run("max_lat",  32'd3,          32'h8000_0000,  32'd0, 1'b0, 4'd5,  0, 0, 36, 33, 33, 32'h8000_0000,  1'b1, 1'b1, 1'b0);
        run("zero_b",   32'd5,          32'd0,          32'd0, 1'b0, 4'd6,  0, 0, 36, 2,  33, 32'd0,          1'b1, 1'b0, 1'b1);
        run("flush",    32'd9,          32'hFFFF_FFFF,  32'd0, 1'b0, 4'd7, 10, 0, 11, 0,  0,  32'd0,          1'b0, 1'b0, 1'b0);
        chk("flush busy", 32'(b1.busy), 32'd0);
        chk("flush held result", b1.result, 32'd0);
        chk("flush held flag_z", 32'(b1.flag_z), 32'd1);
        run("after_flush", 32'd7,       32'd6,          32'd0, 1'b0, 4'd8,  0, 0, 36, 4,  33, 32'd42,         1'b1, 1'b0, 1'b0);
        run("busy_start",  32'd7,       32'd6,          32'd0, 1'b0, 4'd9,  0, 2, 36, 4,  33, 32'd42,         1'b1, 1'b0, 1'b0);
        run("r15",         32'd2,       32'd2,          32'd0, 1'b0, 4'd15, 0, 0, 36, 3,  33, 32'd4,          1'b0, 1'b0, 1'b0);

        // Reset in the middle of an operation
        op_a = 32'd7; op_b = 32'h0000_00FF; acc_en = 0; rd_in = 4'd2; start = 1;
        @(posedge clk); #1;
        start = 0;
        repeat (4) @(posedge clk);
        #2 rst = 0;
        #1 chk_zero("mid_reset");
        @(negedge clk); #2 rst = 1;
        @(posedge clk); #1;

        run("post_reset", 32'h10, 32'h10, 32'd1, 1'b1, 4'd1, 0, 0, 36, 6, 33, 32'd257, 1'b1, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/multiplicador_secuencial.md
# multiplicador_secuencial

Iterative shift-add multiplier for the ARMv4 datapath implementing MUL and MLA: 32×32 → low 32 bits, with optional accumulate. It sits directly downstream of the register bank's read ports and upstream of its write port. Operands come from RD1/RD2 (plus the Rn value for MLA). The result returns to the bank through a write-enable / write-address / write-data triple, together with N and Z flags for the flag logic. The block stalls the pipeline through `busy` while iterating.

## Interface
- WIDTH, 32, operand and result width
- EARLY_TERM, 1, 1 = stop iterating once the remaining multiplier bits are zero; 0 = always run WIDTH iterations
- clk  in  1  single clock, rising-edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  request; accepted only in IDLE
- flush  in  1  synchronous abort (pipeline flush)
- acc_en  in  1  1 = MLA (add op_c), 0 = MUL
- op_a  in  WIDTH  multiplicand (Rm, from RD1)
- op_b  in  WIDTH  multiplier (Rs, from RD2)
- op_c  in  WIDTH  accumulate addend (Rn)
- rd_in  in  4  destination register index
- busy  out  1  high in RUN and DONE
- done  out  1  one-cycle pulse; result valid
- result  out  WIDTH  product/sum; held until the next accepted start
- wa3  out  4  write address to the register bank (latched rd_in)
- we3  out  1  register-bank write enable
- flag_n, flag_z  out  1  result[WIDTH-1] and (result==0); held alongside result

## Operation
- States: IDLE, RUN, DONE.
- IDLE → RUN on `start=1 && flush=0`. On that edge the block latches:
  - mcand ← op_a
  - mplier ← op_b
  - acc ← acc_en ? op_c : 0
  - rd ← rd_in
  - cnt ← 0
- Inputs are sampled only on the accept edge. Later changes on the inputs are ignored.
- Each RUN cycle:
  - if mplier[0]: acc ← acc + mcand (mod 2^WIDTH, carry discarded)
  - mcand ← mcand << 1; mplier ← mplier >> 1; cnt ← cnt + 1 (log2(WIDTH) bits)
- RUN exit condition, evaluated on the shifted values:
  - EARLY_TERM=1: go to DONE when cnt==WIDTH-1 or (mplier>>1)==0.
  - EARLY_TERM=0: go to DONE only when cnt==WIDTH-1.
  - RUN always lasts at least one cycle.
- DONE state:
  - done=1, result=acc, flags updated.
  - we3 = 1 unless rd==15. Writing R15 is unsupported: done still pulses, but we3 stays 0.
  - Returns to IDLE on the next edge unconditionally.
- start is ignored while busy=1; the upstream stage must hold the instruction.
- flush=1 in RUN or DONE: go to IDLE on the next edge. No done and no we3 on that edge. result and flags keep their previous values.
- flush and start together in IDLE: flush wins, and the request is not accepted.
- we3 is never high outside DONE.

## Timing
- Reset (rst=0, asynchronous): state=IDLE. busy, done, we3, flag_n, flag_z = 0. result, wa3, and all internal registers = 0.
- Reset asserted mid-RUN: the operation is aborted immediately, with no done.
- Cycle numbering: the accept edge ends cycle 0.
  - RUN occupies cycles 1..k, where k = max(1, index of op_b's highest set bit + 1) if EARLY_TERM=1, else k = WIDTH.
  - DONE is cycle k+1.
  - IDLE is reached at cycle k+2, which is the earliest next accept.
- Latency ranges:
  - minimum start→done is 2 cycles (op_b ∈ {0,1})
  - maximum is WIDTH+1 = 33 cycles
- busy rises in cycle 1 and falls in cycle k+2. busy is registered from state, with no combinational path from start.
- The result/wa3/we3 pair is presented in the same cycle, so the bank captures WD3=result at the DONE→IDLE edge.

## Test plan
- **MUL 7×6:** op_a=7, op_b=6, acc_en=0, rd_in=3.
  - Response: done in cycle 4, result=42, wa3=3, we3=1, N=0, Z=0; busy high in cycles 1–4.
- **MLA with wrap:** op_a=0xFFFFFFFF, op_b=2, op_c=5, acc_en=1.
  - Response: done in cycle 3, result=0x00000003, N=0, Z=0.
- **Max latency and zero operand:**
  - op_a=3, op_b=0x80000000 → done in cycle 33, result=0x80000000, N=1.
  - op_a=5, op_b=0 → done in cycle 2, result=0, Z=1.
- **Flush:** op_b=0xFFFFFFFF, flush in cycle 10.
  - Response: IDLE in cycle 11, no done/we3, result and flags equal to the previous values.
  - A start issued in cycle 11 is accepted.
- **Reset and start during busy:**
  - rst=0 in cycle 5: all outputs 0 immediately.
  - Separately, a second start pulse in cycle 2 is ignored: exactly one done is produced, with the first operands.
- **R15 destination and EARLY_TERM=0:**
  - rd_in=15, op_a=2, op_b=2 → done pulses, result=4, we3=0.
  - Same operands with EARLY_TERM=0 → done in cycle 33.
